// File: rtl/clock12_set_core.sv
// rtl/clock12_set_core.sv - 12-hour timekeeping core with button-driven set FSM and 24-hour load path
module clock12_set_core #(
  parameter bit TICK_EN_REQUIRED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setEnable,
  input  logic       sec_tick,
  input  logic       pulsed_set,
  input  logic       pulsed_up,
  input  logic       pulsed_down,
  input  logic       extern24_propagate,
  input  logic [4:0] extern24_hours,
  input  logic [5:0] extern24_minutes,
  output logic       propagate,
  output logic       isPM,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       edit_isPM,
  output logic [3:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic [1:0] current_state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_AMPM = 2'd3;

  logic [1:0] state, next_state;
  logic       tick;
  logic       do_enter, do_commit, do_ext, edit_step;
  logic [3:0] ext_h;
  logic       ext_pm;

  assign tick          = TICK_EN_REQUIRED ? sec_tick : 1'b1;
  assign current_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Dropping setEnable aborts any edit without committing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pulsed_set && setEnable) next_state = SET_HOUR;
      SET_HOUR: if (!setEnable) next_state = IDLE; else if (pulsed_set) next_state = SET_MIN;
      SET_MIN:  if (!setEnable) next_state = IDLE; else if (pulsed_set) next_state = SET_AMPM;
      SET_AMPM: if (!setEnable || pulsed_set) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    do_enter  = (state == IDLE) && pulsed_set && setEnable;
    do_commit = (state == SET_AMPM) && pulsed_set && setEnable;
    do_ext    = (state == IDLE) && extern24_propagate &&
                (extern24_hours <= 5'd23) && (extern24_minutes <= 6'd59);
    edit_step = setEnable && !pulsed_set && (pulsed_up ^ pulsed_down);
    ext_pm    = (extern24_hours >= 5'd12);
    if (extern24_hours == 5'd0)      ext_h = 4'd12;
    else if (extern24_hours <= 5'd12) ext_h = 4'(extern24_hours);
    else                             ext_h = 4'(extern24_hours - 5'd12);
  end

  // Commit and extern load are mutually exclusive (different states) and both pre-empt a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours        <= 4'd12;
      minutes      <= 6'd0;
      seconds      <= 6'd0;
      isPM         <= 1'b0;
      edit_hours   <= 4'd12;
      edit_minutes <= 6'd0;
      edit_isPM    <= 1'b0;
      propagate    <= 1'b0;
    end else begin
      propagate <= do_commit;
      if (do_commit) begin
        hours   <= edit_hours;
        minutes <= edit_minutes;
        isPM    <= edit_isPM;
        seconds <= 6'd0;
      end else if (do_ext) begin
        hours   <= ext_h;
        minutes <= extern24_minutes;
        isPM    <= ext_pm;
        seconds <= 6'd0;
      end else if (tick) begin
        if (seconds != 6'd59) begin
          seconds <= seconds + 6'd1;
        end else begin
          seconds <= 6'd0;
          if (minutes != 6'd59) begin
            minutes <= minutes + 6'd1;
          end else begin
            minutes <= 6'd0;
            if (hours == 4'd12) begin
              hours <= 4'd1;
            end else begin
              hours <= hours + 4'd1;
              if (hours == 4'd11) isPM <= ~isPM;
            end
          end
        end
      end

      if (do_enter) begin
        edit_hours   <= hours;
        edit_minutes <= minutes;
        edit_isPM    <= isPM;
      end else if (edit_step) begin
        case (state)
          SET_HOUR:
            if (pulsed_up) edit_hours <= (edit_hours == 4'd12) ? 4'd1 : edit_hours + 4'd1;
            else           edit_hours <= (edit_hours == 4'd1) ? 4'd12 : edit_hours - 4'd1;
          SET_MIN:
            if (pulsed_up) edit_minutes <= (edit_minutes == 6'd59) ? 6'd0 : edit_minutes + 6'd1;
            else           edit_minutes <= (edit_minutes == 6'd0) ? 6'd59 : edit_minutes - 6'd1;
          SET_AMPM: edit_isPM <= ~edit_isPM;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock12_set_core.sv
// tb/tb_clock12_set_core.sv - scoreboard bench for clock12_set_core
module tb_clock12_set_core;

  logic       clk = 1'b0;
  logic       reset, setEnable, sec_tick, pulsed_set, pulsed_up, pulsed_down;
  logic       extern24_propagate;
  logic [4:0] extern24_hours;
  logic [5:0] extern24_minutes;
  logic       propagate, isPM, edit_isPM;
  logic [3:0] hours, edit_hours;
  logic [5:0] minutes, seconds, edit_minutes;
  logic [1:0] current_state;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_state;
  logic       m_ep, m_pm, m_prop;
  logic [3:0] m_eh, m_h;
  logic [5:0] m_em, m_m, m_s;

  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];

  clock12_set_core #(.TICK_EN_REQUIRED(1'b1)) dut (
    .clk(clk), .reset(reset), .setEnable(setEnable), .sec_tick(sec_tick),
    .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
    .extern24_propagate(extern24_propagate), .extern24_hours(extern24_hours),
    .extern24_minutes(extern24_minutes), .propagate(propagate), .isPM(isPM),
    .hours(hours), .minutes(minutes), .seconds(seconds), .edit_isPM(edit_isPM),
    .edit_hours(edit_hours), .edit_minutes(edit_minutes), .current_state(current_state)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] model_pack();
    return {m_state, m_ep, m_eh, m_em, m_pm, m_h, m_m, m_s, m_prop};
  endfunction

  function automatic logic [30:0] dut_pack();
    return {current_state, edit_isPM, edit_hours, edit_minutes, isPM, hours, minutes, seconds, propagate};
  endfunction

  function automatic void m_tick();
    if (m_s != 59) m_s = m_s + 1;
    else begin
      m_s = 0;
      if (m_m != 59) m_m = m_m + 1;
      else begin
        m_m = 0;
        if (m_h == 12) m_h = 1;
        else begin
          if (m_h == 11) m_pm = ~m_pm;
          m_h = m_h + 1;
        end
      end
    end
  endfunction

  // Model must already hold the post-edge expectation when this is called.
  task automatic drive(input logic s, input logic u, input logic d, input logic t, input logic x);
    pulsed_set = s; pulsed_up = u; pulsed_down = d; sec_tick = t; extern24_propagate = x;
    exp_q.push_back(model_pack());
    @(posedge clk); #1;
    obs_q.push_back(dut_pack());
    pulsed_set = 0; pulsed_up = 0; pulsed_down = 0; sec_tick = 0; extern24_propagate = 0;
  endtask

  task automatic set_model_reset();
    m_state = 0; m_ep = 0; m_eh = 12; m_em = 0;
    m_pm = 0; m_h = 12; m_m = 0; m_s = 0; m_prop = 0;
  endtask

  task automatic test_reset();
    logic [30:0] e, o;
    int n = 0;
    reset = 1; set_model_reset();
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    reset = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_tick_hour();
    logic [30:0] e, o;
    int n = 0;
    for (int i = 0; i < 3600; i++) begin m_tick(); drive(0, 0, 0, 1, 0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL tick_hour step %0d got %h want %h", n, o, e); end
      n++;
    end
    checks++;
    if ({hours, minutes, seconds, isPM} !== {4'd1, 6'd0, 6'd0, 1'b0})
      begin errors++; $display("FAIL tick_hour_final got %0d:%0d:%0d pm=%0d want 1:0:0 pm=0", hours, minutes, seconds, isPM); end
  endtask

  task automatic test_rollover();
    logic [30:0] e, o;
    int n = 0;
    int tbl[3][6] = '{'{11, 59, 0, 12, 1, 0}, '{23, 59, 1, 12, 0, 0}, '{12, 59, 1, 1, 1, 0}};
    for (int k = 0; k < 3; k++) begin
      extern24_hours = 5'(tbl[k][0]); extern24_minutes = 6'(tbl[k][1]);
      m_h = 4'(tbl[k][0] > 12 ? tbl[k][0] - 12 : tbl[k][0]); m_m = 6'(tbl[k][1]); m_pm = tbl[k][2][0]; m_s = 0;
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 60; i++) begin m_tick(); drive(0, 0, 0, 1, 0); end
      checks++;
      if ({hours, minutes, seconds, isPM} !== {4'(tbl[k][3]), 6'd0, 6'd0, tbl[k][4][0]})
        begin errors++; $display("FAIL rollover_%0d got %0d:%0d:%0d pm=%0d want %0d:0:0 pm=%0d", k, hours, minutes, seconds, isPM, tbl[k][3], tbl[k][4]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rollover step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_set_sequence();
    logic [30:0] e, o;
    int n = 0;
    reset = 1; set_model_reset(); drive(0, 0, 0, 0, 0); reset = 0;
    for (int i = 0; i < 5; i++) begin m_tick(); drive(0, 0, 0, 1, 0); end
    setEnable = 1;
    m_state = 1; m_eh = 12; m_em = 0; m_ep = 0; drive(1, 0, 0, 0, 0);
    m_eh = 11; drive(0, 0, 1, 0, 0);
    m_eh = 10; drive(0, 0, 1, 0, 0);
    m_state = 2; drive(1, 0, 0, 0, 0);
    m_em = 59; drive(0, 0, 1, 0, 0);
    m_state = 3; drive(1, 0, 0, 0, 0);
    m_ep = 1; drive(0, 1, 0, 0, 0);
    m_state = 0; m_h = 10; m_m = 59; m_pm = 1; m_s = 0; m_prop = 1; drive(1, 0, 0, 0, 0);
    m_prop = 0; drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL set_sequence step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_abort();
    logic [30:0] e, o;
    int n = 0;
    setEnable = 1;
    m_state = 1; m_eh = m_h; m_em = m_m; m_ep = m_pm; drive(1, 0, 0, 0, 0);
    m_state = 2; drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin m_em = (m_em == 59) ? 6'd0 : m_em + 6'd1; drive(0, 1, 0, 0, 0); end
    checks++;
    if (edit_minutes !== 6'd7) begin errors++; $display("FAIL abort_edit_min got %0d want 7", edit_minutes); end
    setEnable = 0; m_state = 0; drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL abort step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_extern();
    logic [30:0] e, o;
    int n = 0;
    int tbl[5][5] = '{'{0, 15, 12, 15, 0}, '{12, 0, 12, 0, 1}, '{23, 45, 11, 45, 1},
                      '{24, 0, 11, 45, 1}, '{5, 60, 11, 45, 1}};
    for (int k = 0; k < 5; k++) begin
      m_tick(); drive(0, 0, 0, 1, 0);
      extern24_hours = 5'(tbl[k][0]); extern24_minutes = 6'(tbl[k][1]);
      if (tbl[k][0] <= 23 && tbl[k][1] <= 59) m_s = 0;
      m_h = 4'(tbl[k][2]); m_m = 6'(tbl[k][3]); m_pm = tbl[k][4][0];
      drive(0, 0, 0, 0, 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL extern step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_set_mode_guards();
    logic [30:0] e, o;
    int n = 0;
    setEnable = 1;
    m_state = 1; m_eh = m_h; m_em = m_m; m_ep = m_pm; drive(1, 0, 0, 0, 0);
    extern24_hours = 5'd5; extern24_minutes = 6'd0; drive(0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0);
    m_state = 2; drive(1, 1, 0, 0, 0);
    setEnable = 0; m_state = 0; drive(0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL set_mode_guards step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_tick_with_load();
    logic [30:0] e, o;
    int n = 0;
    for (int i = 0; i < 3; i++) begin m_tick(); drive(0, 0, 0, 1, 0); end
    extern24_hours = 5'd13; extern24_minutes = 6'd30;
    m_h = 1; m_m = 30; m_s = 0; m_pm = 1; drive(0, 0, 0, 1, 1);
    checks++;
    if ({hours, minutes, seconds, isPM} !== {4'd1, 6'd30, 6'd0, 1'b1})
      begin errors++; $display("FAIL tick_with_load got %0d:%0d:%0d pm=%0d want 1:30:0 pm=1", hours, minutes, seconds, isPM); end
    m_tick(); drive(0, 0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL tick_with_load step %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  initial begin
    reset = 1; setEnable = 0; sec_tick = 0; pulsed_set = 0; pulsed_up = 0; pulsed_down = 0;
    extern24_propagate = 0; extern24_hours = 0; extern24_minutes = 0;
    #1;
    test_reset();
    test_tick_hour();
    test_rollover();
    test_set_sequence();
    test_abort();
    test_extern();
    test_set_mode_guards();
    test_tick_with_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
